pipe_mult_acc: RTL and testbench
================================

# pipe_mult_acc

Parametrised, valid/ready pipelined multiplier with an optional accumulate mode. It replaces the fixed 18x18 unsigned five-register multiplier pipeline with configurable operand widths, pipeline depth and per-transaction signedness. It also adds backpressure and a running accumulator. It sits between the sample datapath and downstream filter/MAC logic wherever a registered product or dot-product is needed.

## Interface
Parameters:
- A_W, 18, width of operand a
- B_W, 18, width of operand b
- PIPE_STAGES, 3, product registers between input and output registers; legal range 1..8
- ACC_GUARD, 4, extra accumulator bits; OUT_W = A_W+B_W+ACC_GUARD

Ports:
- clk  in  1  rising-edge clock; one clock domain; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a, b and the mode bits are valid this cycle
- in_ready  out  1  block accepts the input this cycle
- a  in  A_W  multiplicand
- b  in  B_W  multiplier
- signed_mode  in  1  1: a and b are two's complement; 0: unsigned
- acc_en  in  1  add this product to the accumulator
- acc_clr  in  1  load the accumulator with this product; has priority over acc_en
- out_valid  out  1  p is valid
- out_ready  in  1  downstream accepts p
- p  out  OUT_W  result: the product, or the updated accumulator value

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall (combinational).
- When stall = 1, every pipeline register, valid bit, tag and the accumulator hold.
- When stall = 0, the whole pipeline advances one stage. Empty slots (bubbles) move forward with valid = 0 and are never compacted.
- Input stage registers a, b, signed_mode, acc_en, acc_clr and valid. a and b are sign-extended when signed_mode = 1 and zero-extended otherwise.
- The product is computed as a full-precision (A_W+B_W)-bit value. It then passes through PIPE_STAGES registers, each carrying its mode tags and valid bit.
- At the output stage, when a valid token is loaded, the product is extended to OUT_W (signed or unsigned per its tag):
  - acc_clr = 1: acc <= prod; p <= prod.
  - acc_clr = 0, acc_en = 1: acc <= acc + prod (modulo 2^OUT_W); p <= the new acc.
  - neither set: p <= prod; acc unchanged.
- The accumulator updates only when a valid token is loaded. Bubbles never touch acc or p.
- p holds its last value while out_valid = 0.
- No overflow flag. Accumulation wraps modulo 2^OUT_W.

## Timing
- Latency from an accepted input to out_valid = PIPE_STAGES+2 cycles, with no stall. The default is 5 cycles.
- Throughput is one transaction per cycle while out_ready = 1.
- Reset values: out_valid = 0, p = 0, acc = 0, all internal valid bits 0, in_ready = 1.
- Reset asserted mid-operation discards all in-flight tokens. The first accepted input after reset deasserts appears PIPE_STAGES+2 cycles later.
- Stall in the same cycle as in_valid: the input is not accepted. The source must hold a, b and the mode bits until in_ready = 1.
- out_valid with out_ready = 1 and a new token arriving at the output stage in the same cycle: p is replaced the next cycle and out_valid stays 1.
- If acc_clr and acc_en are both set, the token is treated as acc_clr.

## Test plan
- Defaults, unsigned: a=0x3FFFF, b=0x3FFFF, out_ready=1 -> after 5 cycles out_valid=1 and p=0x0FFFF80001 (OUT_W=40). No other valid outputs appear.
- Signed: a=-3 (0x3FFFD), b=7 -> p = -21, sign-extended to 40 bits (0xFFFFFFFFEB). The same operands with signed_mode=0 give p = 0x3FFFD*7.
- Streaming and bubbles: 10 back-to-back inputs a=i, b=i+1, with a one-cycle in_valid gap after the 4th -> outputs are i*(i+1) in order, with one bubble cycle in the same position.
- Backpressure: hold out_ready=0 for 6 cycles while streaming -> in_ready=0 throughout the stall, no token is lost or duplicated, and p is stable while stalled.
- Accumulate: products 2*3 (acc_clr), 4*5 (acc_en), 1*1 (plain), 6*1 (acc_en) -> p = 6, 26, 1, 32. Then a/b=0xFFFFF... repeated with acc_en until the sum exceeds 2^40 -> p wraps modulo 2^40.
- Reset: assert rst with 3 tokens in flight -> out_valid=0 and p=0 the next cycle, the dropped tokens never appear, and the next acc_en sums start from 0.

Source files
------------

// File: rtl/pipe_mult_acc.sv
// Valid/ready pipelined multiplier with optional running accumulator.
// Input register, PIPE_STAGES product registers, then the output/accumulate register.
module pipe_mult_acc #(
  parameter int A_W         = 18,
  parameter int B_W         = 18,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_GUARD   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [A_W-1:0]                 a,
  input  logic [B_W-1:0]                 b,
  input  logic                           signed_mode,
  input  logic                           acc_en,
  input  logic                           acc_clr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [A_W+B_W+ACC_GUARD-1:0]   p
);

  localparam int P_W   = A_W + B_W;
  localparam int OUT_W = P_W + ACC_GUARD;
  localparam int LAST  = PIPE_STAGES - 1;

  logic              stall_s;
  logic              in_valid_r;
  logic              in_sm_r;
  logic              in_en_r;
  logic              in_clr_r;
  logic [A_W-1:0]    in_a_r;
  logic [B_W-1:0]    in_b_r;
  logic [P_W-1:0]    op_a_s;
  logic [P_W-1:0]    op_b_s;
  logic [P_W-1:0]    prod_s;

  logic [PIPE_STAGES-1:0] pv_r;
  logic [PIPE_STAGES-1:0] psm_r;
  logic [PIPE_STAGES-1:0] pen_r;
  logic [PIPE_STAGES-1:0] pclr_r;
  logic [P_W-1:0]         pprod_r [PIPE_STAGES];

  logic [OUT_W-1:0]  prod_ext_s;
  logic [OUT_W-1:0]  acc_sum_s;
  logic [OUT_W-1:0]  acc_next_s;
  logic [OUT_W-1:0]  p_next_s;
  logic [OUT_W-1:0]  acc_r;
  logic [OUT_W-1:0]  p_r;
  logic              out_valid_r;

  function automatic logic [P_W-1:0] ext_a(input logic [A_W-1:0] v, input logic sm);
    if (sm) begin
      return P_W'($signed(v));
    end else begin
      return P_W'(v);
    end
  endfunction

  function automatic logic [P_W-1:0] ext_b(input logic [B_W-1:0] v, input logic sm);
    if (sm) begin
      return P_W'($signed(v));
    end else begin
      return P_W'(v);
    end
  endfunction

  function automatic logic [OUT_W-1:0] ext_p(input logic [P_W-1:0] v, input logic sm);
    if (sm) begin
      return OUT_W'($signed(v));
    end else begin
      return OUT_W'(v);
    end
  endfunction

  // A full output register that downstream refuses freezes the whole pipe.
  assign stall_s   = out_valid_r & ~out_ready;
  assign in_ready  = ~stall_s;
  assign out_valid = out_valid_r;
  assign p         = p_r;

  // Operands are widened to the product width so one modular multiply covers both signednesses.
  always_comb begin
    op_a_s = ext_a(in_a_r, in_sm_r);
    op_b_s = ext_b(in_b_r, in_sm_r);
    prod_s = op_a_s * op_b_s;
  end

  // Input stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_r <= 1'b0;
      in_sm_r    <= 1'b0;
      in_en_r    <= 1'b0;
      in_clr_r   <= 1'b0;
      in_a_r     <= '0;
      in_b_r     <= '0;
    end else if (!stall_s) begin
      in_valid_r <= in_valid;
      in_sm_r    <= signed_mode;
      in_en_r    <= acc_en;
      in_clr_r   <= acc_clr;
      in_a_r     <= a;
      in_b_r     <= b;
    end
  end

  // Product pipeline; bubbles travel with their slot and are never compacted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r   <= '0;
      psm_r  <= '0;
      pen_r  <= '0;
      pclr_r <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pprod_r[i] <= '0;
      end
    end else if (!stall_s) begin
      for (int i = PIPE_STAGES - 1; i > 0; i--) begin
        pv_r[i]    <= pv_r[i-1];
        psm_r[i]   <= psm_r[i-1];
        pen_r[i]   <= pen_r[i-1];
        pclr_r[i]  <= pclr_r[i-1];
        pprod_r[i] <= pprod_r[i-1];
      end
      pv_r[0]    <= in_valid_r;
      psm_r[0]   <= in_sm_r;
      pen_r[0]   <= in_en_r;
      pclr_r[0]  <= in_clr_r;
      pprod_r[0] <= prod_s;
    end
  end

  // Output-stage next values: clear wins over accumulate, bubbles leave acc and p alone.
  always_comb begin
    prod_ext_s = ext_p(pprod_r[LAST], psm_r[LAST]);
    acc_sum_s  = acc_r + prod_ext_s;
    acc_next_s = acc_r;
    p_next_s   = p_r;
    if (pv_r[LAST]) begin
      if (pclr_r[LAST]) begin
        acc_next_s = prod_ext_s;
        p_next_s   = prod_ext_s;
      end else if (pen_r[LAST]) begin
        acc_next_s = acc_sum_s;
        p_next_s   = acc_sum_s;
      end else begin
        acc_next_s = acc_r;
        p_next_s   = prod_ext_s;
      end
    end else begin
      acc_next_s = acc_r;
      p_next_s   = p_r;
    end
  end

  // Output register and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      acc_r       <= '0;
      p_r         <= '0;
    end else if (!stall_s) begin
      out_valid_r <= pv_r[LAST];
      acc_r       <= acc_next_s;
      p_r         <= p_next_s;
    end
  end

endmodule

// File: tb/tb_pipe_mult_acc.sv
// Scoreboard bench for pipe_mult_acc: randomized and directed stimulus against an arithmetic model.
module tb_pipe_mult_acc;

  localparam int PS    = 3;
  localparam int OUT_W = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [17:0]       a;
  logic [17:0]       b;
  logic              signed_mode;
  logic              acc_en;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  p;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int or_mode = 0;
  int n_stall = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] out_log[$];
  int               out_cyc[$];
  logic [OUT_W-1:0] m_acc;

  pipe_mult_acc #(.A_W(18), .B_W(18), .PIPE_STAGES(PS), .ACC_GUARD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_prod(input logic [17:0] x, input logic [17:0] y, input logic sm);
    longint xv;
    longint yv;
    logic [63:0] full;
    xv = sm ? longint'($signed(x)) : longint'(x);
    yv = sm ? longint'($signed(y)) : longint'(y);
    full = xv * yv;
    return full[OUT_W-1:0];
  endfunction

  task automatic send(input logic [17:0] ta, input logic [17:0] tb, input logic sm, input logic en, input logic clr);
    int guard;
    logic [OUT_W-1:0] pr;
    @(negedge clk);
    a = ta; b = tb; signed_mode = sm; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    #2;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", guard);
    end else begin
      pr = model_prod(ta, tb, sm);
      if (clr) begin
        m_acc = pr;
        exp_q.push_back(pr);
      end else if (en) begin
        m_acc = m_acc + pr;
        exp_q.push_back(m_acc);
      end else begin
        exp_q.push_back(pr);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    or_mode = 0;
    g = 0;
    while (exp_q.size() > 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    repeat (8) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic expect_log(input string nm, input int k, input logic [OUT_W-1:0] e);
    if (k < out_log.size()) begin
      check(nm, out_log[k], e);
    end else begin
      n_vec++; n_err++;
      $display("FAIL %s: output %0d missing, required %0h", nm, k, e);
    end
  endtask

  // Downstream acceptance pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares each transfer against the scoreboard and checks stall behaviour.
  initial begin
    logic [OUT_W-1:0] prev_p;
    logic [OUT_W-1:0] e;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_p = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          check("stall_valid_hold", out_valid, 1);
          check("stall_p_hold", p, prev_p);
        end
        if (out_valid && out_ready) begin
          out_log.push_back(p);
          out_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got p=%0h, required no output", p);
          end else begin
            e = exp_q.pop_front();
            check("p", p, e);
          end
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) n_stall++;
        prev_p = p;
      end
    end
  end

  initial begin
    int n;
    logic [17:0] ra;
    logic [17:0] rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    m_acc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_p", p, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Max unsigned operands and first-token latency.
    send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, PS + 2);
    drain();
    expect_log("unsigned_max", 0, 40'h0FFFF80001);
    check("unsigned_count", out_log.size(), 1);

    // Signed versus unsigned interpretation of the same bits.
    out_log.delete();
    send(18'h3FFFD, 18'd7, 1'b1, 1'b0, 1'b0);
    send(18'h3FFFD, 18'd7, 1'b0, 1'b0, 1'b0);
    drain();
    expect_log("signed_neg", 0, 40'hFFFFFFFFEB);
    expect_log("unsigned_same_bits", 1, 40'h00001BFFEB);

    // Streaming with a single bubble after the fourth token.
    out_log.delete();
    out_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      send(18'(i), 18'(i + 1), 1'b0, 1'b0, 1'b0);
      if (i == 3) @(negedge clk);
    end
    drain();
    check("stream_count", out_log.size(), 10);
    for (int i = 0; i < 10; i++) expect_log("stream_val", i, 40'(i * (i + 1)));
    for (int k = 1; k < 10 && k < out_cyc.size(); k++)
      check("stream_spacing", out_cyc[k] - out_cyc[k-1], (k == 4) ? 2 : 1);

    // Backpressure window while streaming.
    n_stall = 0;
    fork
      begin
        for (int i = 0; i < 14; i++)
          send(18'($urandom), 18'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        or_mode = 2;
        repeat (6) @(negedge clk);
        or_mode = 0;
      end
    join
    drain();
    check("stall_observed", n_stall >= 5, 1);

    // Accumulate sequence, then wrap-around.
    out_log.delete();
    send(18'd2, 18'd3, 1'b0, 1'b0, 1'b1);
    send(18'd4, 18'd5, 1'b0, 1'b1, 1'b0);
    send(18'd1, 18'd1, 1'b0, 1'b0, 1'b0);
    send(18'd6, 18'd1, 1'b0, 1'b1, 1'b0);
    drain();
    expect_log("acc_clr", 0, 40'd6);
    expect_log("acc_en", 1, 40'd26);
    expect_log("acc_plain", 2, 40'd1);
    expect_log("acc_en2", 3, 40'd32);
    send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 19; i++) send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 1'b0);
    drain();
    expect_log("acc_wrap", 23, 40'h3FFF600014);

    // Reset with tokens in flight.
    send(18'd9, 18'd9, 1'b0, 1'b1, 1'b0);
    send(18'd8, 18'd8, 1'b0, 1'b1, 1'b0);
    send(18'd7, 18'd7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_acc = '0;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    @(negedge clk);
    rst = 1'b0;
    out_log.delete();
    send(18'd5, 18'd5, 1'b0, 1'b1, 1'b0);
    drain();
    expect_log("acc_after_reset", 0, 40'd25);
    check("after_reset_count", out_log.size(), 1);

    // Randomized traffic with random downstream backpressure.
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      send(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
